// File: rtl/crc16_pkg.sv
// Shared definitions for the CRC-16 frame datapath: default polynomial and
// initial value, plus the frame-position state encoding used by the checker.
// No ports; imported by crc16_byte_update and crc16_frame_checker.
package crc16_pkg;

  localparam logic [15:0] DEF_POLY = 16'hBAAD;
  localparam logic [15:0] DEF_INIT = 16'h0000;

  // Position within the current frame: how many bytes the holding buffer has
  // seen (IDLE=0, ONE=1, TWO=2), PASS once payload bytes are flowing out.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2,
    PASS = 2'd3
  } state_t;

endpackage

// File: rtl/crc16_byte_update.sv
// Combinational byte-parallel CRC-16 step, MSB-first, non-reflected.
// Latency: zero cycles (pure logic). Backpressure: none, no handshake.
// Ports: crc (current register), data (byte), crc_next (updated register).
module crc16_byte_update
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = DEF_POLY
) (
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  // T(1 << i) = x^(16+i) mod POLY. T is linear over GF(2), so these eight
  // columns are the whole XOR matrix; they fold to constants at elaboration.
  function automatic logic [15:0] t_col(input int i);
    logic [15:0] r;
    r = 16'(1) << (i + 8);
    for (int k = 0; k < 8; k++) begin
      r = r[15] ? ((r << 1) ^ POLY) : (r << 1);
    end
    return r;
  endfunction

  logic [15:0] tcol [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_col
    assign tcol[gi] = t_col(gi);
  end

  logic [7:0]  idx;
  logic [15:0] acc;

  always_comb begin
    idx = crc[15:8] ^ data;
    acc = {crc[7:0], 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (idx[i]) acc = acc ^ tcol[i];
    end
    crc_next = acc;
  end

endmodule

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 checker: strips the trailing 2 CRC bytes, forwards the
// payload, and pulses pass/fail, length and received CRC at end of frame.
// Latency: payload byte leaves 2 accepts + 1 cycle after it enters.
// Backpressure: in_ready = !out_valid || out_ready; no input while output stalls.
// Ports: in_* byte stream with last, out_* payload stream with last,
//        stat_* end-of-frame status (one-cycle stat_valid, fields held).
module crc16_frame_checker
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY  = DEF_POLY,
  parameter logic [15:0] INIT  = DEF_INIT,
  parameter int          LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             stat_valid,
  output logic             stat_crc_ok,
  output logic             stat_runt,
  output logic [LEN_W-1:0] stat_len,
  output logic [15:0]      stat_crc_rx
);

  state_t             state, state_nxt;
  logic [15:0]        crc, crc_nxt;
  logic [7:0]         b0, b1;
  logic [LEN_W-1:0]   cnt, cnt_emit;
  logic               accept, emit, runt;

  crc16_byte_update #(.POLY(POLY)) u_update (
    .crc      (crc),
    .data     (in_data),
    .crc_next (crc_nxt)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // With fewer than two bytes buffered, none of them can be payload yet.
  assign runt     = (state == IDLE) || (state == ONE);
  assign emit     = accept && !runt;
  // Count including this beat's emission, saturating at all-ones.
  assign cnt_emit = (emit && !(&cnt)) ? cnt + LEN_W'(1) : cnt;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_last) begin
        state_nxt = IDLE;
      end else begin
        unique case (state)
          IDLE:    state_nxt = ONE;
          ONE:     state_nxt = TWO;
          TWO:     state_nxt = PASS;
          PASS:    state_nxt = PASS;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      crc         <= INIT;
      b0          <= 8'h00;
      b1          <= 8'h00;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_last    <= 1'b0;
      stat_valid  <= 1'b0;
      stat_crc_ok <= 1'b0;
      stat_runt   <= 1'b0;
      stat_len    <= '0;
      stat_crc_rx <= 16'h0000;
    end else begin
      state      <= state_nxt;
      stat_valid <= accept && in_last;

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= b1;
        out_last  <= in_last;
      end

      if (accept) begin
        if (in_last) begin
          // Buffer now holds the CRC: report it and start the next frame clean.
          crc         <= INIT;
          b0          <= 8'h00;
          b1          <= 8'h00;
          cnt         <= '0;
          stat_crc_ok <= (crc_nxt == 16'h0000) && !runt;
          stat_runt   <= runt;
          stat_len    <= cnt_emit;
          stat_crc_rx <= {b0, in_data};
        end else begin
          crc <= crc_nxt;
          b1  <= b0;
          b0  <= in_data;
          cnt <= cnt_emit;
        end
      end
    end
  end

endmodule
